axi_burst_sched: RTL and testbench

//  Sequencer for the AXI read-increment-write datapath. Issues NUM read bursts (AR) and matching

---
 rtl/axi_burst_sched_if.sv | 24 ++
 rtl/axi_burst_sched.sv | 176 +++++++++++++++++
 tb/tb_axi_burst_sched.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_sched_if.sv
// AXI address-channel and write-response signals seen by the burst scheduler.
// The master modport is the scheduler side; the slave modport is the interconnect side.
interface axi_burst_sched_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  o_rd_addr_vld;
  logic [ADDR_WIDTH-1:0] o_rd_addr;
  logic                  i_rd_addr_rdy;
  logic                  o_wr_addr_vld;
  logic [ADDR_WIDTH-1:0] o_wr_addr;
  logic                  i_wr_addr_rdy;
  logic                  i_wr_resp_vld;
  logic [1:0]            i_wr_resp;

  modport master (
    output o_rd_addr_vld, o_rd_addr, o_wr_addr_vld, o_wr_addr,
    input  i_rd_addr_rdy, i_wr_addr_rdy, i_wr_resp_vld, i_wr_resp
  );

  modport slave (
    input  o_rd_addr_vld, o_rd_addr, o_wr_addr_vld, o_wr_addr,
    output i_rd_addr_rdy, i_wr_addr_rdy, i_wr_resp_vld, i_wr_resp
  );
endinterface

// File: rtl/axi_burst_sched.sv
// Issues NUM read bursts and matching write bursts, bounds reads in flight by a
// credit limit, counts write responses and reports completion plus sticky errors.
module axi_burst_sched #(
  parameter int ADDR_WIDTH      = 32,
  parameter int CNT_WIDTH       = 8,
  parameter int BURST_BYTES     = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_rd_base,
  input  logic [ADDR_WIDTH-1:0] i_wr_base,
  input  logic [CNT_WIDTH-1:0]  i_num_bursts,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  axi_burst_sched_if.master     axi
);

  localparam int CW1 = CNT_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] STRIDE  = ADDR_WIDTH'(BURST_BYTES);
  localparam logic [CW1-1:0]        MAX_OUT = CW1'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  ar_cnt_q, ar_cnt_d;
  logic [CNT_WIDTH-1:0]  aw_cnt_q, aw_cnt_d;
  logic [CNT_WIDTH-1:0]  b_cnt_q, b_cnt_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [ADDR_WIDTH-1:0] rd_base_q, rd_base_d;
  logic [ADDR_WIDTH-1:0] wr_base_q, wr_base_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_vld_q, wr_vld_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  err_q, err_d;

  logic                  ar_hs;
  logic                  aw_hs;
  logic [CW1-1:0]        outstanding;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ar_cnt_q  <= '0;
      aw_cnt_q  <= '0;
      b_cnt_q   <= '0;
      num_q     <= '0;
      rd_base_q <= '0;
      wr_base_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ar_cnt_q  <= ar_cnt_d;
      aw_cnt_q  <= aw_cnt_d;
      b_cnt_q   <= b_cnt_d;
      num_q     <= num_d;
      rd_base_q <= rd_base_d;
      wr_base_q <= wr_base_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ar_cnt_d  = ar_cnt_q;
    aw_cnt_d  = aw_cnt_q;
    b_cnt_d   = b_cnt_q;
    num_d     = num_q;
    rd_base_d = rd_base_q;
    wr_base_d = wr_base_q;
    rd_vld_d  = rd_vld_q;
    rd_addr_d = rd_addr_q;
    wr_vld_d  = wr_vld_q;
    wr_addr_d = wr_addr_q;
    err_d     = err_q;

    ar_hs       = rd_vld_q & axi.i_rd_addr_rdy;
    aw_hs       = wr_vld_q & axi.i_wr_addr_rdy;
    outstanding = {1'b0, ar_cnt_q} - {1'b0, b_cnt_q};

    case (state_q)
      S_IDLE: begin
        if (axi.i_wr_resp_vld) begin
          err_d = 1'b1;
        end
        // An accepted start wins over a stray response in the same cycle.
        if (i_start) begin
          ar_cnt_d  = '0;
          aw_cnt_d  = '0;
          b_cnt_d   = '0;
          num_d     = i_num_bursts;
          rd_base_d = i_rd_base;
          wr_base_d = i_wr_base;
          err_d     = 1'b0;
          state_d   = (i_num_bursts == '0) ? S_DONE : S_RUN;
        end
      end

      S_RUN: begin
        if (rd_vld_q) begin
          if (ar_hs) begin
            rd_vld_d = 1'b0;
            ar_cnt_d = ar_cnt_q + 1'b1;
          end
        end else if ((ar_cnt_q < num_q) && (outstanding < MAX_OUT)) begin
          rd_vld_d  = 1'b1;
          rd_addr_d = rd_base_q + ADDR_WIDTH'(ar_cnt_q) * STRIDE;
        end

        // A write burst is only offered once its read burst has been accepted.
        if (wr_vld_q) begin
          if (aw_hs) begin
            wr_vld_d = 1'b0;
            aw_cnt_d = aw_cnt_q + 1'b1;
          end
        end else if (aw_cnt_q < ar_cnt_q) begin
          wr_vld_d  = 1'b1;
          wr_addr_d = wr_base_q + ADDR_WIDTH'(aw_cnt_q) * STRIDE;
        end

        // b_cnt never exceeds aw_cnt, so a same-cycle AW handshake always covers this B.
        if (axi.i_wr_resp_vld) begin
          if ((b_cnt_q < aw_cnt_q) || aw_hs) begin
            b_cnt_d = b_cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
          if (axi.i_wr_resp != 2'b00) begin
            err_d = 1'b1;
          end
        end

        if (b_cnt_q == num_q) begin
          state_d  = S_DONE;
          rd_vld_d = 1'b0;
          wr_vld_d = 1'b0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        if (axi.i_wr_resp_vld) begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_busy            = (state_q == S_RUN);
  assign o_done            = (state_q == S_DONE);
  assign o_err             = err_q;
  assign axi.o_rd_addr_vld = rd_vld_q;
  assign axi.o_rd_addr     = rd_addr_q;
  assign axi.o_wr_addr_vld = wr_vld_q;
  assign axi.o_wr_addr     = wr_addr_q;

endmodule

// File: tb/tb_axi_burst_sched.sv
// Directed bench for axi_burst_sched: table of full runs against a small AXI
// responder, plus hand sequences for back-pressure, credit limit and reset.
module tb_axi_burst_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] rd_base;
  logic [31:0] wr_base;
  logic [7:0]  num;
  logic        busy;
  logic        done;
  logic        err;

  int n_chk  = 0;
  int n_fail = 0;

  axi_burst_sched_if #(.ADDR_WIDTH(32)) axi ();

  axi_burst_sched #(
    .ADDR_WIDTH(32),
    .CNT_WIDTH(8),
    .BURST_BYTES(8),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(start),
    .i_rd_base(rd_base),
    .i_wr_base(wr_base),
    .i_num_bursts(num),
    .o_busy(busy),
    .o_done(done),
    .o_err(err),
    .axi(axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          num;
    logic [31:0] rd_base;
    logic [31:0] wr_base;
    int          b_delay;   // cycles from AW handshake to B (0 = same cycle)
    int          err_idx;   // index of the B carrying SLVERR, -1 for none
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic start_run(input int n, input logic [31:0] rb, input logic [31:0] wb);
    @(negedge clk);
    start   = 1'b1;
    num     = 8'(n);
    rd_base = rb;
    wr_base = wb;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rst_pulse(input string tag);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_rst_arvalid"}, 32'(axi.o_rd_addr_vld), 32'd0);
    chk({tag, "_rst_awvalid"}, 32'(axi.o_wr_addr_vld), 32'd0);
    chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
    rst = 1'b0;
    axi.i_rd_addr_rdy = 1'b1;
    axi.i_wr_addr_rdy = 1'b1;
    axi.i_wr_resp_vld = 1'b0;
    axi.i_wr_resp     = 2'b00;
  endtask

  // Full run: all ready high, B returned b_delay cycles after each AW handshake.
  task automatic run_vec(input int idx, input vec_t v);
    int ar_n, aw_n, b_n, done_cyc, last_b_cyc, err_cyc;
    bit finished;
    int due_q[$];
    ar_n = 0; aw_n = 0; b_n = 0;
    done_cyc = -1; last_b_cyc = -1; err_cyc = -1;
    finished = 1'b0;
    axi.i_rd_addr_rdy = 1'b1;
    axi.i_wr_addr_rdy = 1'b1;
    axi.i_wr_resp_vld = 1'b0;
    axi.i_wr_resp     = 2'b00;
    start_run(v.num, v.rd_base, v.wr_base);
    chk($sformatf("v%0d_busy_after_start", idx), 32'(busy), 32'(v.num != 0));
    chk($sformatf("v%0d_err_cleared", idx), 32'(err), 32'd0);
    for (int c = 1; c <= 400; c++) begin
      if (err_cyc >= 0 && c == err_cyc + 1)
        chk($sformatf("v%0d_err_rise", idx), 32'(err), 32'd1);
      if (done_cyc >= 0) begin
        chk($sformatf("v%0d_done_one_cycle", idx), 32'(done), 32'd0);
        finished = 1'b1;
        break;
      end
      if (done) begin
        done_cyc = c;
        chk($sformatf("v%0d_err_at_done", idx), 32'(err), 32'(v.exp_err));
      end
      if (axi.o_rd_addr_vld && axi.i_rd_addr_rdy) begin
        chk($sformatf("v%0d_araddr%0d", idx, ar_n), axi.o_rd_addr, v.rd_base + 32'(ar_n) * 32'd8);
        ar_n++;
      end
      if (axi.o_wr_addr_vld && axi.i_wr_addr_rdy) begin
        chk($sformatf("v%0d_awaddr%0d", idx, aw_n), axi.o_wr_addr, v.wr_base + 32'(aw_n) * 32'd8);
        aw_n++;
        due_q.push_back(c + v.b_delay);
      end
      axi.i_wr_resp_vld = 1'b0;
      axi.i_wr_resp     = 2'b00;
      if (due_q.size() > 0 && due_q[0] <= c) begin
        void'(due_q.pop_front());
        axi.i_wr_resp_vld = 1'b1;
        if (b_n == v.err_idx) begin
          axi.i_wr_resp = 2'b10;
          err_cyc = c;
        end
        b_n++;
        last_b_cyc = c;
      end
      @(negedge clk);
    end
    axi.i_wr_resp_vld = 1'b0;
    axi.i_wr_resp     = 2'b00;
    chk($sformatf("v%0d_finished", idx), 32'(finished), 32'd1);
    chk($sformatf("v%0d_ar_count", idx), 32'(ar_n), 32'(v.num));
    chk($sformatf("v%0d_aw_count", idx), 32'(aw_n), 32'(v.num));
    chk($sformatf("v%0d_b_count", idx), 32'(b_n), 32'(v.num));
    // B sampled at edge k bumps the count; DONE is entered one edge later.
    chk($sformatf("v%0d_done_cycle", idx), 32'(done_cyc),
        (v.num == 0) ? 32'd1 : 32'(last_b_cyc + 2));
  endtask

  initial begin
    int ar_n;
    bit got;
    logic [31:0] held;
    vec_t v;

    vecs[0] = '{num: 4, rd_base: 32'h0000_0000, wr_base: 32'h0000_1000, b_delay: 2, err_idx: -1, exp_err: 1'b0};
    vecs[1] = '{num: 3, rd_base: 32'h0000_0200, wr_base: 32'h0000_3000, b_delay: 2, err_idx: 1,  exp_err: 1'b1};
    vecs[2] = '{num: 0, rd_base: 32'h0000_0050, wr_base: 32'h0000_0060, b_delay: 2, err_idx: -1, exp_err: 1'b0};
    vecs[3] = '{num: 2, rd_base: 32'hFFFF_FFF8, wr_base: 32'hFFFF_FFF0, b_delay: 1, err_idx: -1, exp_err: 1'b0};
    vecs[4] = '{num: 5, rd_base: 32'h0000_0100, wr_base: 32'h0000_2000, b_delay: 0, err_idx: -1, exp_err: 1'b0};
    vecs[5] = '{num: 6, rd_base: 32'h0000_0800, wr_base: 32'h0000_0900, b_delay: 5, err_idx: -1, exp_err: 1'b0};

    rst = 1'b1; start = 1'b0; num = '0; rd_base = '0; wr_base = '0;
    axi.i_rd_addr_rdy = 1'b1;
    axi.i_wr_addr_rdy = 1'b1;
    axi.i_wr_resp_vld = 1'b0;
    axi.i_wr_resp     = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_arvalid", 32'(axi.o_rd_addr_vld), 32'd0);
    chk("reset_awvalid", 32'(axi.o_wr_addr_vld), 32'd0);
    rst = 1'b0;

    // Stray B while idle sets the sticky error.
    @(negedge clk);
    axi.i_wr_resp_vld = 1'b1;
    @(negedge clk);
    axi.i_wr_resp_vld = 1'b0;
    chk("idle_b_err", 32'(err), 32'd1);
    @(negedge clk);
    chk("idle_b_err_sticky", 32'(err), 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_vec(i, vecs[i]);
      $display("vector %0d: num=%0d rd=0x%08h wr=0x%08h checks=%0d failures=%0d",
               i, vecs[i].num, vecs[i].rd_base, vecs[i].wr_base, n_chk, n_fail);
    end

    // Credit limit: with B withheld only two reads are accepted, then one B frees a slot.
    axi.i_rd_addr_rdy = 1'b1;
    axi.i_wr_addr_rdy = 1'b1;
    start_run(4, 32'h0, 32'h1000);
    ar_n = 0;
    for (int c = 0; c < 15; c++) begin
      if (axi.o_rd_addr_vld && axi.i_rd_addr_rdy) ar_n++;
      @(negedge clk);
    end
    chk("credit_ar_count", 32'(ar_n), 32'd2);
    chk("credit_arvalid_low", 32'(axi.o_rd_addr_vld), 32'd0);
    axi.i_wr_resp_vld = 1'b1;
    @(negedge clk);
    axi.i_wr_resp_vld = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (axi.o_rd_addr_vld) begin
        got = 1'b1;
        chk("credit_resume_addr", axi.o_rd_addr, 32'h10);
        break;
      end
      @(negedge clk);
    end
    chk("credit_resume", 32'(got), 32'd1);
    $display("credit sequence: ar_accepted=%0d resumed=%0d", ar_n, got);
    rst_pulse("credit");

    // Back-pressure: ARVALID and ARADDR hold while ARREADY stays low.
    axi.i_rd_addr_rdy = 1'b0;
    start_run(2, 32'h40, 32'h80);
    got = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (axi.o_rd_addr_vld) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("hold_arvalid_seen", 32'(got), 32'd1);
    held = axi.o_rd_addr;
    chk("hold_first_addr", held, 32'h40);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold_arvalid_c%0d", c), 32'(axi.o_rd_addr_vld), 32'd1);
      chk($sformatf("hold_araddr_c%0d", c), axi.o_rd_addr, held);
    end
    chk("hold_no_awvalid", 32'(axi.o_wr_addr_vld), 32'd0);
    $display("backpressure sequence: araddr=0x%08h held 5 cycles", held);
    rst_pulse("hold");

    // Reset in the middle of a run, then a fresh single-burst run.
    start_run(4, 32'h0, 32'h1000);
    ar_n = 0;
    for (int c = 0; c < 20 && ar_n < 2; c++) begin
      if (axi.o_rd_addr_vld && axi.i_rd_addr_rdy) ar_n++;
      @(negedge clk);
    end
    chk("midrun_ar_count", 32'(ar_n), 32'd2);
    chk("midrun_busy", 32'(busy), 32'd1);
    rst_pulse("midrun");
    v = '{num: 1, rd_base: 32'h0000_7000, wr_base: 32'h0000_7100, b_delay: 2, err_idx: -1, exp_err: 1'b0};
    run_vec(6, v);
    $display("reset sequence: restart num=1 checks=%0d failures=%0d", n_chk, n_fail);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
